// File: rtl/ram_block_engine.sv
// Block fill / copy / checksum initiator for the 256x8 data RAM bus.
// Every output is registered; each RAM bus cycle lasts exactly one clock.
module ram_block_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_src,
    input  logic [7:0] cmd_dst,
    input  logic [7:0] cmd_len,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] ram_address,
    output logic       n_cs,
    output logic       n_oe,
    output logic       n_we,
    inout  wire  [7:0] ram_data,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;

    state_t     state, state_nx;
    logic [1:0] op;
    logic [7:0] src, dst, fill_byte;
    logic [7:0] idx, rem, acc;
    logic [7:0] wdata, wdata_nx, addr_nx, idx_nx, acc_sum;
    logic       drive, last;

    assign ram_data  = drive ? wdata : 8'hzz;
    assign dbg_state = state;

    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so cmd_valid is ignored at every other time.
    always_comb begin
        state_nx = state;
        addr_nx  = ram_address;
        wdata_nx = wdata;
        last     = (rem == 8'd0);
        idx_nx   = idx + 8'd1;
        acc_sum  = acc + ram_data;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_FILL: begin
                            state_nx = WR;
                            addr_nx  = cmd_dst;
                            wdata_nx = cmd_data;
                        end
                        OP_COPY, OP_SUM: begin
                            state_nx = RD;
                            addr_nx  = cmd_src;
                        end
                        default: state_nx = DONE;
                    endcase
                end
            end
            RD: begin
                if (op == OP_COPY) begin
                    // the read byte goes straight into the write-data holding register
                    state_nx = WR;
                    addr_nx  = dst + idx;
                    wdata_nx = ram_data;
                end else if (last) begin
                    state_nx = DONE;
                end else begin
                    addr_nx = src + idx_nx;
                end
            end
            WR: begin
                if (last) begin
                    state_nx = DONE;
                end else if (op == OP_COPY) begin
                    state_nx = RD;
                    addr_nx  = src + idx_nx;
                end else begin
                    addr_nx = dst + idx_nx;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            op          <= 2'b00;
            src         <= 8'h00;
            dst         <= 8'h00;
            fill_byte   <= 8'h00;
            idx         <= 8'h00;
            rem         <= 8'h00;
            acc         <= 8'h00;
            result      <= 8'h00;
            wdata       <= 8'h00;
            drive       <= 1'b0;
            ram_address <= 8'h00;
            n_cs        <= 1'b1;
            n_oe        <= 1'b1;
            n_we        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            state       <= state_nx;
            ram_address <= addr_nx;
            wdata       <= wdata_nx;
            drive       <= (state_nx == WR);
            n_cs        <= !((state_nx == RD) || (state_nx == WR));
            n_oe        <= (state_nx != RD);
            n_we        <= (state_nx != WR);
            busy        <= (state_nx != IDLE);
            cmd_ready   <= (state_nx == IDLE);
            done        <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op        <= cmd_op;
                        src       <= cmd_src;
                        dst       <= cmd_dst;
                        fill_byte <= cmd_data;
                        idx       <= 8'h00;
                        rem       <= cmd_len;
                        acc       <= 8'h00;
                    end
                end
                RD: begin
                    if (op == OP_SUM) begin
                        acc <= acc_sum;
                        if (last) begin
                            result <= acc_sum;
                        end else begin
                            idx <= idx_nx;
                            rem <= rem - 8'd1;
                        end
                    end
                end
                WR: begin
                    if (!last) begin
                        idx <= idx_nx;
                        rem <= rem - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_engine.sv
// Bench for ram_block_engine: RAM model on the bus, random commands checked against
// an array-level model of fill/copy/checksum plus exact bus-cycle and done timing.
module tb_ram_block_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_src = 8'h00, cmd_dst = 8'h00, cmd_len = 8'h00, cmd_data = 8'h00;
    logic       cmd_ready, busy, done, n_cs, n_oe, n_we;
    logic [7:0] result, ram_address;
    logic [1:0] dbg_state;
    wire  [7:0] ram_data;

    ram_block_engine dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .busy(busy), .done(done), .result(result),
        .ram_address(ram_address), .n_cs(n_cs), .n_oe(n_oe), .n_we(n_we),
        .ram_data(ram_data), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: asynchronous read while selected and output-enabled, write at edge
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = 8'h00, pre_val = 8'h00;
    assign ram_data = (!n_cs && !n_oe) ? mem[ram_address] : 8'hzz;
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (!n_cs && !n_we) mem[ram_address] <= ram_data;
    end

    // bus monitor: entries are {cycle, is_write, address}
    logic [40:0] act_q[$];
    logic [40:0] exp_q[$];
    int          done_q[$];
    always @(negedge clk) begin
        if (!n_cs) act_q.push_back({cyc, ~n_we, ram_address});
        if (done) done_q.push_back(cyc);
    end

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_result = 8'h00;

    // reference model
    function automatic logic [7:0] apply_ref(input logic [1:0] op, input logic [7:0] src,
                                             input logic [7:0] dst, input logic [7:0] len,
                                             input logic [7:0] data);
        logic [7:0] s = 8'h00;
        for (int k = 0; k <= int'(len); k++) begin
            case (op)
                2'b00: ref_mem[dst + 8'(k)] = data;
                2'b01: ref_mem[dst + 8'(k)] = ref_mem[src + 8'(k)];
                2'b10: s = s + ref_mem[src + 8'(k)];
                default: ;
            endcase
        end
        return s;
    endfunction

    function automatic void build_exp(input logic [1:0] op, input logic [7:0] src,
                                      input logic [7:0] dst, input logic [7:0] len,
                                      input int t);
        int j = 0;
        if (op == 2'b11) return;
        for (int k = 0; k <= int'(len); k++) begin
            if (op != 2'b00) begin
                exp_q.push_back({t + j, 1'b0, src + 8'(k)});
                j++;
            end
            if (op != 2'b10) begin
                exp_q.push_back({t + j, 1'b1, dst + 8'(k)});
                j++;
            end
        end
    endfunction

    // driver tasks
    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_val = v;
        ref_mem[a] = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                         input logic [7:0] len, input logic [7:0] data, output int t);
        int n = 0;
        @(negedge clk);
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_data = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d clocks, required 1", cmd_ready, n);
            cmd_valid = 1'b0;
            t = -1;
        end else begin
            @(posedge clk);
            #1;
            t = cyc;
            cmd_valid = 1'b0;
            act_q.delete();
            done_q.delete();
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < lim);
        if (busy) begin
            checks++;
            $display("FAIL idle_timeout: busy=%b after %0d clocks, required 0", busy, n);
        end
    endtask

    // tests
    task automatic test_reset;
        for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", cmd_ready); else passes++;
        checks++; if (result !== 8'h00) $display("FAIL rst_result: got %h want 00", result); else passes++;
        checks++; if (ram_address !== 8'h00) $display("FAIL rst_addr: got %h want 00", ram_address); else passes++;
        checks++;
        if ({n_cs, n_oe, n_we} !== 3'b111) $display("FAIL rst_bus: got %b want 111", {n_cs, n_oe, n_we});
        else passes++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill;
        int t, bad;
        logic [7:0] s;
        issue(2'b00, 8'h00, 8'h10, 8'd3, 8'hA5, t);
        s = apply_ref(2'b00, 8'h00, 8'h10, 8'd3, 8'hA5);
        exp_q.delete();
        build_exp(2'b00, 8'h00, 8'h10, 8'd3, t);
        wait_idle(50);
        bad = (act_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[j]) if (bad == 0 && act_q[j] !== exp_q[j]) bad = 1;
        checks++;
        if (bad != 0) $display("FAIL fill_bus: got %0d cycles want %0d (or wrong cycle/address)", act_q.size(), exp_q.size());
        else passes++;
        checks++;
        if (done_q.size() != 1 || done_q[0] != t + 4) $display("FAIL fill_done: got %0d pulses want 1 at clock 5", done_q.size());
        else passes++;
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++; if (bad != 0) $display("FAIL fill_mem: %0d bytes differ, want 0", bad); else passes++;
        checks++;
        if (mem[8'h13] !== 8'hA5) $display("FAIL fill_last: got %h want a5", mem[8'h13]); else passes++;
    endtask

    task automatic test_copy_wrap;
        int t, bad;
        logic [7:0] s;
        poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03); poke(8'h01, 8'h04);
        issue(2'b01, 8'hFE, 8'h40, 8'd3, 8'h00, t);
        s = apply_ref(2'b01, 8'hFE, 8'h40, 8'd3, 8'h00);
        exp_q.delete();
        build_exp(2'b01, 8'hFE, 8'h40, 8'd3, t);
        wait_idle(50);
        bad = (act_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[j]) if (bad == 0 && act_q[j] !== exp_q[j]) bad = 1;
        checks++;
        if (bad != 0) $display("FAIL copy_bus: got %0d cycles want %0d (or wrong cycle/address)", act_q.size(), exp_q.size());
        else passes++;
        checks++;
        if (done_q.size() != 1 || done_q[0] != t + 8) $display("FAIL copy_done: got %0d pulses want 1 at clock 9", done_q.size());
        else passes++;
        checks++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'h01020304)
            $display("FAIL copy_data: got %h%h%h%h want 01020304", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
        else passes++;
    endtask

    task automatic test_checksum;
        int t, n;
        logic [7:0] s;
        poke(8'h20, 8'h80); poke(8'h21, 8'h90); poke(8'h22, 8'h05);
        issue(2'b10, 8'h20, 8'h00, 8'd2, 8'h00, t);
        s = apply_ref(2'b10, 8'h20, 8'h00, 8'd2, 8'h00);
        exp_result = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        checks++;
        if (!done || cyc != t + 3) $display("FAIL sum_done: done=%b at clock %0d want 1 at clock 4", done, cyc - t + 1);
        else passes++;
        checks++; if (result !== 8'h15) $display("FAIL sum_result: got %h want 15", result); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (result !== 8'h15) $display("FAIL sum_hold: got %h want 15", result); else passes++;
    endtask

    task automatic test_reset_midfill;
        int t, bad;
        issue(2'b00, 8'h00, 8'h60, 8'd15, 8'h3C, t);
        for (int k = 0; k < 3; k++) ref_mem[8'h60 + 8'(k)] = 8'h3C;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL midrst_ctl: busy/done/ready got %b%b%b want 001", busy, done, cmd_ready);
        else passes++;
        checks++; if (result !== 8'h00) $display("FAIL midrst_result: got %h want 00", result); else passes++;
        checks++;
        if (ram_address !== 8'h00 || {n_cs, n_oe, n_we} !== 3'b111)
            $display("FAIL midrst_bus: addr %h ctl %b want 00 111", ram_address, {n_cs, n_oe, n_we});
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        exp_result = 8'h00;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done_q.size() != 0)
            $display("FAIL midrst_after: ready %b done pulses %0d want 1 0", cmd_ready, done_q.size());
        else passes++;
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++; if (bad != 0) $display("FAIL midrst_mem: %0d bytes differ, want 0", bad); else passes++;
    endtask

    task automatic test_abort;
        int t, bad;
        issue(2'b01, 8'h80, 8'hA0, 8'd3, 8'h00, t);
        ref_mem[8'hA0] = ref_mem[8'h80];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (n_cs !== 1'b1 || busy !== 1'b0) $display("FAIL abort_idle: n_cs %b busy %b want 1 0", n_cs, busy);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (done_q.size() != 0 || act_q.size() != 3)
            $display("FAIL abort_cycles: done pulses %0d bus cycles %0d want 0 3", done_q.size(), act_q.size());
        else passes++;
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++; if (bad != 0) $display("FAIL abort_mem: %0d bytes differ, want 0", bad); else passes++;
    endtask

    task automatic test_back_to_back;
        int ta, tb, n, bad;
        logic [7:0] s;
        @(negedge clk);
        cmd_op = 2'b00; cmd_dst = 8'hB0; cmd_len = 8'd2; cmd_data = 8'h11; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        ta = cyc;
        act_q.delete();
        done_q.delete();
        cmd_dst = 8'hC0; cmd_len = 8'd1; cmd_data = 8'h22;
        tb = -1;
        n = 0;
        while (tb < 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                tb = cyc;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (tb != ta + 5) $display("FAIL b2b_accept: second accept %0d clocks after first, want 5", tb - ta);
        else passes++;
        s = apply_ref(2'b00, 8'h00, 8'hB0, 8'd2, 8'h11);
        s = apply_ref(2'b00, 8'h00, 8'hC0, 8'd1, 8'h22);
        exp_q.delete();
        build_exp(2'b00, 8'h00, 8'hB0, 8'd2, ta);
        build_exp(2'b00, 8'h00, 8'hC0, 8'd1, ta + 5);
        wait_idle(50);
        bad = (act_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[j]) if (bad == 0 && act_q[j] !== exp_q[j]) bad = 1;
        checks++;
        if (bad != 0) $display("FAIL b2b_bus: got %0d cycles want %0d (or wrong cycle/address)", act_q.size(), exp_q.size());
        else passes++;
        checks++;
        if (done_q.size() != 2 || done_q[0] != ta + 3 || done_q[1] != ta + 7)
            $display("FAIL b2b_done: got %0d pulses want 2 at clocks 4 and 8", done_q.size());
        else passes++;
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++; if (bad != 0) $display("FAIL b2b_mem: %0d bytes differ, want 0", bad); else passes++;
    endtask

    task automatic test_random;
        int t, bad;
        logic [1:0] op;
        logic [7:0] src, dst, len, data, s;
        for (int it = 0; it < 24; it++) begin
            op   = 2'($urandom_range(0, 3));
            src  = 8'($urandom);
            dst  = 8'($urandom);
            len  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 20));
            data = 8'($urandom);
            issue(op, src, dst, len, data, t);
            s = apply_ref(op, src, dst, len, data);
            if (op == 2'b10) exp_result = s;
            exp_q.delete();
            build_exp(op, src, dst, len, t);
            wait_idle(700);
            bad = (act_q.size() != exp_q.size()) ? 1 : 0;
            foreach (exp_q[j]) if (bad == 0 && act_q[j] !== exp_q[j]) bad = 1;
            checks++;
            if (bad != 0) $display("FAIL rnd_bus[%0d] op %0d: got %0d cycles want %0d (or wrong cycle/address)", it, op, act_q.size(), exp_q.size());
            else passes++;
            checks++;
            if (done_q.size() != 1 || done_q[0] != t + exp_q.size())
                $display("FAIL rnd_done[%0d] op %0d: got %0d pulses want 1 at clock %0d", it, op, done_q.size(), exp_q.size() + 1);
            else passes++;
            checks++;
            if (result !== exp_result) $display("FAIL rnd_result[%0d] op %0d: got %h want %h", it, op, result, exp_result);
            else passes++;
            bad = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
            checks++; if (bad != 0) $display("FAIL rnd_mem[%0d] op %0d: %0d bytes differ, want 0", it, op, bad); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy_wrap();
        test_checksum();
        test_reset_midfill();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ram_block_engine.md
# ram_block_engine

Bus initiator for the 256x8 data RAM: it drives the RAM's `n_cs`/`n_oe`/`n_we`/address/bidirectional data pins to carry out block commands issued over a valid/ready command port. It sits beside the CPU datapath on the same RAM bus, on the initiator side of that bus. It performs three operations on byte ranges: fill, copy and 8-bit additive checksum. Bus arbitration with the CPU is external; this block owns the bus only while `busy` is high.

## Interface
Parameters: none; data width 8, address width 8, both fixed.

- clk  input  1  rising-edge clock for all state
- reset  input  1  reset, synchronous and active-low; one clock, `clk`
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command (high only in IDLE)
- cmd_op  input  2  00 fill, 01 copy, 10 checksum, 11 reserved (accepted, completes as a zero-length no-op)
- cmd_src  input  8  source start address (copy, checksum)
- cmd_dst  input  8  destination start address (fill, copy)
- cmd_len  input  8  byte count minus one (0 means 1 byte, 255 means 256 bytes)
- cmd_data  input  8  fill byte
- busy  output  1  command in progress
- done  output  1  one-cycle pulse when a command completes
- result  output  8  checksum of the last completed checksum command
- ram_address  output  8  RAM address
- n_cs, n_oe, n_we  output  1 each  RAM chip select, output enable and write enable, all active-low
- ram_data  inout  8  RAM data; driven only in write cycles, otherwise `z`

## Operation
- Every output is registered. States: IDLE, RD, WR, DONE.
- Handshake: a command is accepted on the rising edge where `cmd_valid && cmd_ready`. All `cmd_*` fields are captured at that edge. An index counter `i` clears to 0 and a remaining-byte counter loads `cmd_len`.
- Bus cycles are exactly one clock long:
  - Read cycle: `n_cs=0`, `n_oe=0`, `n_we=1`. `ram_data` is sampled at the rising edge that ends the cycle.
  - Write cycle: `n_cs=0`, `n_oe=1`, `n_we=0`, `ram_data` driven. The RAM captures the data at the edge that ends the cycle.
  - Idle bus: `n_cs=n_oe=n_we=1`, `ram_address` holds its last value, `ram_data=z`.
- Fill: state WR only. Each cycle writes `cmd_data` to `dst+i`. One byte per clock.
- Copy: alternates RD at `src+i` (byte latched into an 8-bit holding register) with WR of that register to `dst+i`. Two clocks per byte.
- Checksum: state RD only. Each cycle reads `src+i`, and `acc = (acc + ram_data) mod 256`. `acc` clears at accept.
- Address arithmetic is mod 256: `0xFF+1` wraps to `0x00`. A length of 256 touches every address exactly once.
- Copy order is ascending, byte by byte. With overlapping ranges where `dst > src`, the source bytes are overwritten before they are read (pattern propagation). This is the defined behaviour, not an error.
- After the last byte, the engine enters DONE for one cycle: `done=1`, `busy=1`, bus idle. For checksum, `result` loads `acc` at the DONE entry edge. `result` holds until the next checksum completes.
- `cmd_op=11`: the engine goes directly to DONE with no bus cycles; `result` is unchanged.
- `cmd_valid` while not in IDLE is ignored; `cmd_ready=0`.

## Timing
- Reset asserted (`reset=0` sampled at an edge):
  - State goes to IDLE.
  - `busy=0`, `done=0`, `cmd_ready=1`, `result=0x00`, `ram_address=0x00`.
  - `n_cs=n_oe=n_we=1`, `ram_data=z`.
- Reset mid-operation aborts at that edge. There is no `done` pulse. Bytes already written stay in RAM. A write cycle that coincides with the reset edge still completes in the RAM.
- Latency, with the command accepted at edge T and N = `cmd_len+1`:
  - First bus cycle occupies the clock after T.
  - Fill: N bus clocks; `done` in clock N+1 after T.
  - Copy: 2N bus clocks; `done` in clock 2N+1.
  - Checksum: N bus clocks; `done` in clock N+1, with `result` valid in that same clock.
- `busy` rises in the clock after T and falls after the DONE clock. `cmd_ready` is the inverse of `busy`.
- Back-to-back: a command presented during DONE is accepted at the edge ending DONE's successor clock (IDLE). Minimum gap between commands is one IDLE clock.

## Test plan
- Reset: hold `reset=0` for 2 clocks mid-fill, then release. Required: all reset values above hold in the clock after the first reset edge, with no `done` pulse; `cmd_ready=1` after release.
- Fill: `dst=0x10`, `len=3`, `data=0xA5`. Required: 4 write cycles at addresses 0x10–0x13 in clocks 1–4 after accept; `done` in clock 5; RAM[0x10..0x13]=0xA5; RAM[0x14] unchanged.
- Copy with wrap: RAM[FE,FF,00,01]=01,02,03,04; `src=0xFE`, `dst=0x40`, `len=3`. Required: bus sequence RD FE, WR 40, RD FF, WR 41, RD 00, WR 42, RD 01, WR 43; `done` in clock 9; RAM[40..43]=01..04.
- Checksum overflow: RAM[20..22]=0x80,0x90,0x05; `src=0x20`, `len=2`. Required: `result=0x15` in the `done` clock, held afterwards.
- Abort: reset after 3 bus clocks of a 4-byte copy. Required: only the first destination byte is written; bus is idle in the next clock; no `done` pulse.
- Busy ignore and back-to-back: hold `cmd_valid=1` with a second command throughout a fill. Required: the second command is not accepted until IDLE; it is then accepted and its first bus cycle follows.
